univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg_if.sv | 24 ++
 rtl/univ_shift_reg.sv | 67 ++++++
 tb/tb_univ_shift_reg.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_if.sv
// Data/control bundle for univ_shift_reg: mode, parallel/serial inputs and
// the registered word with its derived outputs.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_msb;
    logic             sin_lsb;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             sout_msb;
    logic             sout_lsb;

    modport master (
        output mode, d, sin_msb, sin_lsb,
        input  q, qb, sout_msb, sout_lsb
    );

    modport slave (
        input  mode, d, sin_msb, sin_lsb,
        output q, qb, sout_msb, sout_lsb
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Multi-mode WIDTH-bit register: hold/load/shift/rotate/toggle/clear with
// true/complement and serial chaining outputs, synchronous active-high reset.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input logic             clk,
    input logic             rst,
    univ_shift_reg_if.slave bus
);
    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_SHL  = 3'b011;
    localparam logic [2:0] M_ROTR = 3'b100;
    localparam logic [2:0] M_ROTL = 3'b101;
    localparam logic [2:0] M_TGL  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] rotr;
    logic [WIDTH-1:0] rotl;

    // A single-bit word has no interior slice; shifts collapse to the serial
    // input and rotates collapse to hold.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shr  = bus.sin_msb;
            assign shl  = bus.sin_lsb;
            assign rotr = q;
            assign rotl = q;
        end else begin : g_wn
            assign shr  = {bus.sin_msb, q[WIDTH-1:1]};
            assign shl  = {q[WIDTH-2:0], bus.sin_lsb};
            assign rotr = {q[0], q[WIDTH-1:1]};
            assign rotl = {q[WIDTH-2:0], q[WIDTH-1]};
        end
    endgenerate

    always_comb begin
        q_nxt = q;
        case (bus.mode)
            M_HOLD:  q_nxt = q;
            M_LOAD:  q_nxt = bus.d;
            M_SHR:   q_nxt = shr;
            M_SHL:   q_nxt = shl;
            M_ROTR:  q_nxt = rotr;
            M_ROTL:  q_nxt = rotl;
            M_TGL:   q_nxt = q ^ bus.d;
            M_CLR:   q_nxt = {WIDTH{1'b0}};
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) q <= RESET_VAL;
        else     q <= q_nxt;
    end

    assign bus.q        = q;
    assign bus.qb       = ~q;
    assign bus.sout_msb = q[WIDTH-1];
    assign bus.sout_lsb = q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: an 8-bit instance (RESET_VAL=A5) and
// a 1-bit instance, driven on the falling edge and checked after the rising edge.
module tb_univ_shift_reg;
    typedef struct packed {
        logic       rst;
        logic [2:0] mode;
        logic [7:0] d;
        logic       smsb;
        logic       slsb;
        logic [7:0] exp;
    } stim_t;

    logic clk = 1'b0;
    logic rst8, rst1;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] sb8[$];
    logic       sb1[$];

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(8)) bus8 ();
    univ_shift_reg_if #(.WIDTH(1)) bus1 ();

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk(clk), .rst(rst8), .bus(bus8.slave)
    );
    univ_shift_reg #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1.slave)
    );

    // Independent reference of one clock of the 8-bit register.
    function automatic logic [7:0] model8(logic [7:0] q, stim_t s);
        if (s.rst) return 8'hA5;
        case (s.mode)
            3'b001:  return s.d;
            3'b010:  return {s.smsb, q[7:1]};
            3'b011:  return {q[6:0], s.slsb};
            3'b100:  return {q[0], q[7:1]};
            3'b101:  return {q[6:0], q[7]};
            3'b110:  return q ^ s.d;
            3'b111:  return 8'h00;
            default: return q;
        endcase
    endfunction

    task automatic drive8(input stim_t s);
        @(negedge clk);
        rst8         = s.rst;
        bus8.mode    = s.mode;
        bus8.d       = s.d;
        bus8.sin_msb = s.smsb;
        bus8.sin_lsb = s.slsb;
        sb8.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input stim_t s);
        @(negedge clk);
        rst1         = s.rst;
        bus1.mode    = s.mode;
        bus1.d       = s.d[0];
        bus1.sin_msb = s.smsb;
        bus1.sin_lsb = s.slsb;
        sb1.push_back(s.exp[0]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t t[6] = '{
            '{1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 8'hA5},
            '{1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'hA5},
            '{1'b0, 3'b000, 8'h33, 1'b1, 1'b1, 8'hA5},
            '{1'b0, 3'b000, 8'hFF, 1'b0, 1'b1, 8'hA5},
            '{1'b1, 3'bxxx, 8'h00, 1'b1, 1'b0, 8'hA5},
            '{1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'hA5}
        };
        foreach (t[i]) begin
            logic [7:0] e;
            drive8(t[i]);
            e = sb8.pop_front();
            tests++;
            if ({bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb} !== {e, ~e, e[7], e[0]}) begin
                fails++;
                $display("FAIL reset[%0d]: q=%h qb=%h so=%b%b, want q=%h qb=%h", i,
                         bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb, e, ~e);
            end
        end
    endtask

    task automatic test_shift_right();
        stim_t t[4] = '{
            '{1'b0, 3'b001, 8'h96, 1'b0, 1'b0, 8'h96},
            '{1'b0, 3'b010, 8'h00, 1'b1, 1'b0, 8'hCB},
            '{1'b0, 3'b010, 8'h00, 1'b0, 1'b1, 8'h65},
            '{1'b0, 3'b010, 8'h00, 1'b1, 1'b0, 8'hB2}
        };
        foreach (t[i]) begin
            logic [7:0] e;
            drive8(t[i]);
            e = sb8.pop_front();
            tests++;
            if ({bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb} !== {e, ~e, e[7], e[0]}) begin
                fails++;
                $display("FAIL shr[%0d]: q=%h qb=%h so=%b%b, want q=%h", i,
                         bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb, e);
            end
        end
    endtask

    task automatic test_shift_rotate();
        stim_t t[6] = '{
            '{1'b0, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81},
            '{1'b0, 3'b011, 8'h00, 1'b1, 1'b0, 8'h02},
            '{1'b0, 3'b101, 8'h00, 1'b1, 1'b1, 8'h04},
            '{1'b0, 3'b100, 8'h00, 1'b1, 1'b1, 8'h02},
            '{1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 8'h01},
            '{1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 8'h80}
        };
        foreach (t[i]) begin
            logic [7:0] e;
            drive8(t[i]);
            e = sb8.pop_front();
            tests++;
            if ({bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb} !== {e, ~e, e[7], e[0]}) begin
                fails++;
                $display("FAIL shrot[%0d]: q=%h qb=%h so=%b%b, want q=%h", i,
                         bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb, e);
            end
        end
    endtask

    task automatic test_toggle_clear();
        stim_t t[5] = '{
            '{1'b0, 3'b001, 8'h0F, 1'b0, 1'b0, 8'h0F},
            '{1'b0, 3'b110, 8'hFF, 1'b0, 1'b0, 8'hF0},
            '{1'b0, 3'b110, 8'h3C, 1'b0, 1'b0, 8'hCC},
            '{1'b0, 3'b111, 8'hFF, 1'b1, 1'b1, 8'h00},
            '{1'b0, 3'b110, 8'h5A, 1'b0, 1'b0, 8'h5A}
        };
        foreach (t[i]) begin
            logic [7:0] e;
            drive8(t[i]);
            e = sb8.pop_front();
            tests++;
            if ({bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb} !== {e, ~e, e[7], e[0]}) begin
                fails++;
                $display("FAIL tglclr[%0d]: q=%h qb=%h so=%b%b, want q=%h", i,
                         bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t t[5] = '{
            '{1'b0, 3'b001, 8'hC3, 1'b0, 1'b0, 8'hC3},
            '{1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 8'h87},
            '{1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 8'h0F},
            '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'hA5},
            '{1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 8'h4B}
        };
        foreach (t[i]) begin
            logic [7:0] e;
            drive8(t[i]);
            e = sb8.pop_front();
            tests++;
            if ({bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb} !== {e, ~e, e[7], e[0]}) begin
                fails++;
                $display("FAIL rstmid[%0d]: q=%h qb=%h so=%b%b, want q=%h", i,
                         bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb, e);
            end
        end
    endtask

    // Random mode every cycle against the reference model; no idle cycles.
    task automatic test_back_to_back();
        logic [7:0] m = 8'h4B;
        for (int i = 0; i < 60; i++) begin
            stim_t s;
            logic [7:0] e;
            s.rst  = ($urandom_range(0, 15) == 0);
            s.mode = 3'($urandom_range(0, 7));
            s.d    = 8'($urandom);
            s.smsb = 1'($urandom);
            s.slsb = 1'($urandom);
            m      = model8(m, s);
            s.exp  = m;
            drive8(s);
            e = sb8.pop_front();
            tests++;
            if ({bus8.q, bus8.qb, bus8.sout_msb, bus8.sout_lsb} !== {e, ~e, e[7], e[0]}) begin
                fails++;
                $display("FAIL b2b[%0d] mode=%b rst=%b: q=%h, want q=%h", i,
                         s.mode, s.rst, bus8.q, e);
            end
        end
    endtask

    task automatic test_width1();
        stim_t t[9] = '{
            '{1'b1, 3'b001, 8'h01, 1'b1, 1'b1, 8'h00},
            '{1'b0, 3'b010, 8'h00, 1'b1, 1'b0, 8'h01},
            '{1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 8'h01},
            '{1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 8'h01},
            '{1'b0, 3'b110, 8'h01, 1'b0, 1'b0, 8'h00},
            '{1'b0, 3'b011, 8'h00, 1'b0, 1'b1, 8'h01},
            '{1'b0, 3'b011, 8'h00, 1'b1, 1'b0, 8'h00},
            '{1'b0, 3'b001, 8'h01, 1'b0, 1'b0, 8'h01},
            '{1'b0, 3'b111, 8'h01, 1'b1, 1'b1, 8'h00}
        };
        foreach (t[i]) begin
            logic e;
            drive1(t[i]);
            e = sb1.pop_front();
            tests++;
            if ({bus1.q, bus1.qb, bus1.sout_msb, bus1.sout_lsb} !== {e, ~e, e, e}) begin
                fails++;
                $display("FAIL w1[%0d]: q=%b qb=%b so=%b%b, want q=%b", i,
                         bus1.q, bus1.qb, bus1.sout_msb, bus1.sout_lsb, e);
            end
        end
    endtask

    initial begin
        rst8 = 1'b0; rst1 = 1'b0;
        bus8.mode = 3'b000; bus8.d = '0; bus8.sin_msb = 1'b0; bus8.sin_lsb = 1'b0;
        bus1.mode = 3'b000; bus1.d = '0; bus1.sin_msb = 1'b0; bus1.sin_lsb = 1'b0;
        test_reset();
        test_shift_right();
        test_shift_rotate();
        test_toggle_clear();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
